// File: rtl/rv32_mod_decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv32_mod_decode_stage_ctrl
// Brief    : Decode-stage holding buffer (output + skid register) that
//            classifies the RV32 instruction format at capture time.
// Revision : 1.0 - initial release
// ============================================================================
module rv32_mod_decode_stage_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [5:0]  out_format,
    output logic        out_illegal
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [5:0] c_FMT_R    = 6'b100000;
    localparam logic [5:0] c_FMT_I    = 6'b010000;
    localparam logic [5:0] c_FMT_S    = 6'b001000;
    localparam logic [5:0] c_FMT_B    = 6'b001100;
    localparam logic [5:0] c_FMT_U    = 6'b000010;
    localparam logic [5:0] c_FMT_J    = 6'b000011;
    localparam logic [5:0] c_FMT_NONE = 6'b000000;

    logic [1:0]  r_state;

    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic [5:0]  r_out_format;
    logic        r_out_illegal;

    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [5:0]  r_skid_format;
    logic        r_skid_illegal;

    logic [5:0]  w_in_format;
    logic        w_in_illegal;
    logic        w_in_fire;
    logic        w_out_fire;

    // Opcode classification; anything unlisted (including compressed
    // encodings with [1:0] != 2'b11) falls through to illegal.
    always_comb begin
        w_in_format  = c_FMT_NONE;
        w_in_illegal = 1'b0;
        case (in_instr[6:0])
            7'b0110011: w_in_format = c_FMT_R;
            7'b0010011,
            7'b0000011,
            7'b1100111,
            7'b1110011,
            7'b0001111: w_in_format = c_FMT_I;
            7'b0100011: w_in_format = c_FMT_S;
            7'b1100011: w_in_format = c_FMT_B;
            7'b0110111,
            7'b0010111: w_in_format = c_FMT_U;
            7'b1101111: w_in_format = c_FMT_J;
            default: begin
                w_in_format  = c_FMT_NONE;
                w_in_illegal = 1'b1;
            end
        endcase
    end

    assign in_ready   = (r_state != S_FULL);
    assign out_valid  = (r_state != S_EMPTY);
    assign w_in_fire  = in_valid && in_ready && !flush;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_EMPTY;
            r_out_instr    <= 32'd0;
            r_out_pc       <= 32'd0;
            r_out_format   <= 6'd0;
            r_out_illegal  <= 1'b0;
            r_skid_instr   <= 32'd0;
            r_skid_pc      <= 32'd0;
            r_skid_format  <= 6'd0;
            r_skid_illegal <= 1'b0;
        end else if (flush) begin
            // Data registers keep stale contents; only the state is cleared.
            r_state <= S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        r_out_instr   <= in_instr;
                        r_out_pc      <= in_pc;
                        r_out_format  <= w_in_format;
                        r_out_illegal <= w_in_illegal;
                        r_state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_out_instr   <= in_instr;
                        r_out_pc      <= in_pc;
                        r_out_format  <= w_in_format;
                        r_out_illegal <= w_in_illegal;
                    end else if (w_in_fire) begin
                        r_skid_instr   <= in_instr;
                        r_skid_pc      <= in_pc;
                        r_skid_format  <= w_in_format;
                        r_skid_illegal <= w_in_illegal;
                        r_state        <= S_FULL;
                    end else if (w_out_fire) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_fire) begin
                        r_out_instr   <= r_skid_instr;
                        r_out_pc      <= r_skid_pc;
                        r_out_format  <= r_skid_format;
                        r_out_illegal <= r_skid_illegal;
                        r_state       <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign out_instr   = r_out_instr;
    assign out_pc      = r_out_pc;
    assign out_format  = r_out_format;
    assign out_illegal = r_out_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32_mod_decode_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32_mod_decode_stage_ctrl
// Brief    : Directed self-checking bench for the decode-stage buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32_mod_decode_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  out_format;
    logic        out_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    rv32_mod_decode_stage_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .out_format (out_format),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    logic [31:0] sw_instr [10];
    logic [5:0]  sw_fmt   [10];
    logic        sw_ill   [10];

    initial begin
        sw_instr[0] = 32'h0000006F; sw_fmt[0] = 6'b000011; sw_ill[0] = 1'b0;
        sw_instr[1] = 32'h00000063; sw_fmt[1] = 6'b001100; sw_ill[1] = 1'b0;
        sw_instr[2] = 32'h000000B7; sw_fmt[2] = 6'b000010; sw_ill[2] = 1'b0;
        sw_instr[3] = 32'h00002023; sw_fmt[3] = 6'b001000; sw_ill[3] = 1'b0;
        sw_instr[4] = 32'h002081B3; sw_fmt[4] = 6'b100000; sw_ill[4] = 1'b0;
        sw_instr[5] = 32'h00000001; sw_fmt[5] = 6'b000000; sw_ill[5] = 1'b1;
        sw_instr[6] = 32'h00000073; sw_fmt[6] = 6'b010000; sw_ill[6] = 1'b0;
        sw_instr[7] = 32'h00000017; sw_fmt[7] = 6'b000010; sw_ill[7] = 1'b0;
        sw_instr[8] = 32'h0000007F; sw_fmt[8] = 6'b000000; sw_ill[8] = 1'b1;
        sw_instr[9] = 32'h00000067; sw_fmt[9] = 6'b010000; sw_ill[9] = 1'b0;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'hFFFF_FFFF;
        in_pc = 32'hFFFF_FFFF; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready",  {31'd0, in_ready},    32'd1);
        chk("rst_out_valid", {31'd0, out_valid},   32'd0);
        chk("rst_instr",     out_instr,            32'd0);
        chk("rst_pc",        out_pc,               32'd0);
        chk("rst_format",    {26'd0, out_format},  32'd0);
        chk("rst_illegal",   {31'd0, out_illegal}, 32'd0);

        // Single transfer
        out_ready = 1'b1;
        push(32'h00500093, 32'h100);
        step();
        in_valid = 1'b0;
        chk("single_valid",   {31'd0, out_valid},   32'd1);
        chk("single_format",  {26'd0, out_format},  32'h10);
        chk("single_illegal", {31'd0, out_illegal}, 32'd0);
        chk("single_pc",      out_pc,               32'h100);
        chk("single_instr",   out_instr,            32'h00500093);
        step();
        chk("single_drain",   {31'd0, out_valid},   32'd0);

        // Classification sweep
        for (int i = 0; i < 10; i++) begin
            push(sw_instr[i], 32'h1000 + 32'(i * 4));
            step();
            in_valid = 1'b0;
            chk("sweep_format",  {26'd0, out_format},  {26'd0, sw_fmt[i]});
            chk("sweep_illegal", {31'd0, out_illegal}, {31'd0, sw_ill[i]});
            chk("sweep_instr",   out_instr,            sw_instr[i]);
            step();
        end

        // Backpressure: A then B, C refused while full
        out_ready = 1'b0;
        push(32'h00100013, 32'h200);
        step();
        chk("bp_a_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_a_ready", {31'd0, in_ready},  32'd1);
        push(32'h00000037, 32'h204);
        step();
        chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_full_pc",    out_pc,            32'h200);
        push(32'h00000033, 32'h208);
        step();
        chk("bp_hold_pc",     out_pc,               32'h200);
        chk("bp_hold_instr",  out_instr,            32'h00100013);
        chk("bp_hold_format", {26'd0, out_format},  32'h10);
        chk("bp_hold_ready",  {31'd0, in_ready},    32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_b_pc",     out_pc,              32'h204);
        chk("bp_b_format", {26'd0, out_format}, 32'h02);
        chk("bp_b_ready",  {31'd0, in_ready},   32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(32'h00000013 | (32'(i) << 20), 32'h300 + 32'(i * 4));
            step();
            chk("stream_ready", {31'd0, in_ready},  32'd1);
            chk("stream_valid", {31'd0, out_valid}, 32'd1);
            chk("stream_pc",    out_pc,             32'h300 + 32'(i * 4));
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", {31'd0, out_valid}, 32'd0);

        // Flush in FULL with in_valid on the same cycle
        out_ready = 1'b0;
        push(32'h00000013, 32'h400);
        step();
        push(32'h00000013, 32'h404);
        step();
        chk("fl_full_ready", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        push(32'h00000013, 32'h408);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_ready", {31'd0, in_ready},  32'd1);
        out_ready = 1'b1;
        step();
        chk("fl_no_input", {31'd0, out_valid}, 32'd0);

        // Flush in ONE with in_valid: the accepted-looking input must vanish
        out_ready = 1'b0;
        push(32'h00000013, 32'h410);
        step();
        flush = 1'b1;
        push(32'h00000013, 32'h414);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl1_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        push(32'h00000013, 32'h500);
        step();
        in_valid = 1'b0;
        chk("fl1_next_pc", out_pc, 32'h500);
        step();
        chk("fl1_no_stale", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream while FULL
        out_ready = 1'b0;
        push(32'h00000063, 32'h600);
        step();
        push(32'h0000006F, 32'h604);
        step();
        chk("rf_full_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        push(32'h00000013, 32'h608);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rf_valid",  {31'd0, out_valid},  32'd0);
        chk("rf_ready",  {31'd0, in_ready},   32'd1);
        chk("rf_format", {26'd0, out_format}, 32'd0);
        chk("rf_pc",     out_pc,              32'd0);
        out_ready = 1'b1;
        step();
        chk("rf_still_empty", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
